// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hffff_ffff;

    typedef enum logic [1:0] {
        WAIT,
        FETCH,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and occupancy count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    push_while_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - PC generation, pipelined imem reads and decode-facing instruction queue
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0,
    parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] inst_pc,
    output logic              fetch_halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [WORD_W-1:0]   fetch_pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       outstanding_next;
    logic [CW-1:0]       discard;
    logic [CW-1:0]       dq_count;
    logic [CW-1:0]       sq_count;
    logic [CW:0]         in_use;
    logic                accept;
    logic                resp_fresh;
    logic                resp_keep;
    logic                halt_enq;
    logic                pop;
    logic                dq_empty;
    logic                dq_full;
    logic                sq_empty;
    logic                sq_full;
    logic [2*WORD_W-1:0] dq_head;
    logic [WORD_W-1:0]   sq_head;
    logic                unused_status;

    // Queued words plus reads in flight can never exceed the queue size, so every response has a slot.
    assign in_use     = {1'b0, dq_count} + {1'b0, outstanding};
    assign imem_req   = (state == FETCH) && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc;
    assign accept     = imem_req && imem_ready;

    // A fresh response always owns the oldest shadow PC; words after a halt are dropped.
    assign resp_fresh = imem_rvalid && (discard == '0) && !redirect_valid;
    assign resp_keep  = resp_fresh && (state != HALT);
    assign halt_enq   = resp_keep && (imem_rdata == HALT_WORD);

    assign inst_valid        = !dq_empty;
    assign {inst, inst_pc}   = inst_valid ? dq_head : '0;
    assign pop               = inst_valid && inst_ready;
    assign fetch_halted      = (state == HALT);
    assign unused_status     = &{1'b0, dq_full, sq_empty, sq_full, sq_count};

    always_comb begin
        state_next = state;
        case (state)
            WAIT:    state_next = FETCH;
            FETCH:   if (halt_enq) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = WAIT;
        endcase
        if (redirect_valid) state_next = FETCH;
    end

    always_comb begin
        outstanding_next = outstanding;
        if (accept) outstanding_next = outstanding_next + CW'(1);
        if (imem_rvalid && (outstanding != '0)) outstanding_next = outstanding_next - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                discard  <= outstanding_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd1;
                if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    sync_fifo #(.WIDTH(2*WORD_W), .DEPTH(DEPTH)) u_data_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (resp_keep),
        .push_data ({imem_rdata, sq_head}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (dq_head),
        .full      (dq_full),
        .empty     (dq_empty),
        .count     (dq_count)
    );

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_pc_shadow_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp_fresh),
        .flush     (redirect_valid),
        .head      (sq_head),
        .full      (sq_full),
        .empty     (sq_empty),
        .count     (sq_count)
    );

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the decode stage.
- Generates word-addressed PCs, issues pipelined reads to instruction memory, and buffers returned words with their PCs in a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute: flushes queued words and discards stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries; also the limit on queued plus outstanding reads (power of two, >= 2).
- RESET_PC, 32'h0, first PC fetched after reset.
- HALT_WORD, 32'hffffffff, instruction encoding that stops fetching.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  read request valid
- imem_addr  output  32  word address of the request
- imem_ready  input  1  memory accepts the request this cycle
- imem_rvalid  input  1  read data valid; responses arrive in order, latency >= 1
- imem_rdata  input  32  returned instruction word
- redirect_valid  input  1  taken branch/jump from execute
- redirect_pc  input  32  new fetch PC
- inst_valid  output  1  FIFO head valid for decode
- inst_ready  input  1  decode consumes the head
- inst  output  32  head instruction
- inst_pc  output  32  PC of the head instruction
- fetch_halted  output  1  HALT_WORD has been enqueued; fetching stopped

Behaviour:
- Reset is asynchronous, active-low. Under reset: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_halted=0. FSM=WAIT, FIFO empty, outstanding=0, discard=0.
- FSM states and transitions:
  - WAIT: one cycle after rst_n deasserts, then -> FETCH.
  - FETCH: issues requests.
  - HALT: entered when a response equal to HALT_WORD is enqueued. fetch_halted=1, imem_req=0.
  - HALT -> FETCH only on redirect_valid.
  - WAIT -> FETCH on redirect_valid, which also loads the PC.
- Issue rule: imem_req=1 in FETCH while (count + outstanding) < DEPTH and redirect_valid=0.
  - A request is accepted when imem_req and imem_ready are both high.
  - On acceptance, fetch_pc <= fetch_pc+1 (wraps 32'hffffffff -> 0) and outstanding increments.
  - imem_addr = fetch_pc.
  - Each request's PC is pushed into an internal PC shadow queue (depth DEPTH).
- Response: imem_rvalid decrements outstanding.
  - If discard>0: discard decrements and the data is dropped.
  - Else {rdata, shadow PC} is enqueued.
  - The credit rule guarantees the FIFO never overflows. A push while full is a design error; assert in simulation.
- Output: inst, inst_pc, and inst_valid are registered FIFO-head values.
  - The head is popped when inst_valid and inst_ready are both high.
  - First instruction appears at inst_valid no earlier than 1 cycle after its imem_rvalid.
  - Full throughput of 1 instruction/cycle with a 1-cycle memory.
- Redirect (same cycle):
  - FIFO and shadow queue flushed; inst_valid=0 next cycle.
  - fetch_pc <= redirect_pc.
  - discard <= outstanding minus responses this cycle, plus any request accepted this cycle. No request is issued in the redirect cycle.
  - State -> FETCH.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle is a no-op.
- Simultaneous push and pop on a full FIFO: allowed; count unchanged.
- Simultaneous push and pop on an empty FIFO: the word is enqueued; the head is valid next cycle.
- Counter widths: count, outstanding, and discard are $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset asserted mid-operation: everything returns to reset values immediately; in-flight responses after reset are not tracked.
  - The memory model must be reset together with this block.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum {WAIT, FETCH, HALT}
  - WORD_W=32
  - HALT_WORD default
- One sub-module: sync_fifo (parameterised WIDTH/DEPTH, push/pop/flush, full/empty/count).
  - Instantiated twice: instruction+PC data queue (64 bits) and PC shadow queue (32 bits).

Test Plan:
- Reset, 1-cycle memory always ready, memory[i]=i+100 → addresses 0,1,2… issued back-to-back; decode with inst_ready=1 sees inst=100,101,102 with inst_pc=0,1,2, one per cycle.
- inst_ready=0 for 10 cycles → at most DEPTH=4 requests issued; count+outstanding never exceeds 4; after release, inst=100..103 in order, no loss or duplication.
- 3-cycle memory latency, redirect_pc=0x40 while 3 reads outstanding → those 3 responses are dropped; next valid output is inst_pc=0x40, inst=memory[0x40].
- Redirect in the same cycle as imem_rvalid and a pop → response dropped, pop ignored, inst_valid=0 next cycle, fetch resumes at the redirect target.
- memory[5]=32'hffffffff → fetch_halted=1 after it is enqueued, no further imem_req, inst 0..5 delivered; then redirect_valid with pc=0x10 → fetching resumes at 0x10, fetch_halted=0.
- Assert rst_n low mid-stream with 2 queued and 2 outstanding → outputs at reset values the same cycle; after release the first request is to RESET_PC.
